// File: rtl/crypto_wallet_ram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crypto_wallet_ram_arb_pkg : shared types/constants for RAM arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package crypto_wallet_ram_arb_pkg;

  localparam int DEPTH_DEF  = 8000;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WIPE  = 2'd2,
    DONE  = 2'd3
  } zstate_e;

endpackage
`default_nettype wire

// File: rtl/crypto_wallet_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crypto_wallet_rr_arb2 : 2-way round-robin grant, remembers last win  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module crypto_wallet_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  output logic [1:0] gnt_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_o = 2'b00;
    if (enable_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Only an issued grant moves the fairness pointer.
  assign last_grant_d = (gnt_o != 2'b00) ? gnt_o[1] : last_grant_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/crypto_wallet_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crypto_wallet_ram_arbiter : 2-master RAM arbiter with key zeroizer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module crypto_wallet_ram_arbiter
  import crypto_wallet_ram_arb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   rq0_address,
  input  logic [DATA_W/8-1:0] rq0_byteenable,
  input  logic                rq0_read,
  input  logic                rq0_write,
  input  logic [DATA_W-1:0]   rq0_writedata,
  output logic                rq0_waitrequest,
  output logic [DATA_W-1:0]   rq0_readdata,
  output logic                rq0_readdatavalid,

  input  logic [ADDR_W-1:0]   rq1_address,
  input  logic [DATA_W/8-1:0] rq1_byteenable,
  input  logic                rq1_read,
  input  logic                rq1_write,
  input  logic [DATA_W-1:0]   rq1_writedata,
  output logic                rq1_waitrequest,
  output logic [DATA_W-1:0]   rq1_readdata,
  output logic                rq1_readdatavalid,

  input  logic                zeroize_req,
  output logic                zeroize_busy,
  output logic                zeroize_done,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int                BE_W      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  zstate_e             state_q, state_d;
  logic [ADDR_W-1:0]   wipe_cnt_q, wipe_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_owner_q, rd_owner_d;
  logic                rd_oor_q, rd_oor_d;
  logic [DATA_W-1:0]   rd0_hold_q, rd1_hold_q;

  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                arb_en;
  logic                gnt_any;
  logic                sel;
  logic                sel_write;
  logic                sel_in_range;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BE_W-1:0]     sel_be;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W-1:0]   rd_word;

  assign req    = {rq1_read | rq1_write, rq0_read | rq0_write};
  // Gating with reset_n keeps every waitrequest high while reset is held.
  assign arb_en = reset_n && (state_q == IDLE);

  crypto_wallet_rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req),
    .enable_i (arb_en),
    .gnt_o    (gnt)
  );

  assign gnt_any      = |gnt;
  assign sel          = gnt[1];
  assign sel_addr     = sel ? rq1_address    : rq0_address;
  assign sel_be       = sel ? rq1_byteenable : rq0_byteenable;
  assign sel_wdata    = sel ? rq1_writedata  : rq0_writedata;
  assign sel_write    = sel ? rq1_write      : rq0_write;
  assign sel_in_range = (sel_addr <= LAST_ADDR);

  assign rq0_waitrequest = ~gnt[0];
  assign rq1_waitrequest = ~gnt[1];

  always_comb begin
    mem_address    = sel_addr;
    mem_byteenable = sel_be;
    mem_writedata  = sel_wdata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (state_q == WIPE) begin
      mem_address    = wipe_cnt_q;
      mem_byteenable = '1;
      mem_writedata  = DATA_W'(ZERO_WORD);
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else if (gnt_any && sel_in_range) begin
      mem_chipselect = 1'b1;
      mem_write      = sel_write;
    end
  end

  // Out-of-range reads are still answered, with a zero word.
  assign rd_pend_d  = gnt_any & ~sel_write;
  assign rd_owner_d = sel;
  assign rd_oor_d   = ~sel_in_range;
  assign rd_word    = rd_oor_q ? '0 : mem_readdata;

  assign rq0_readdatavalid = rd_pend_q & ~rd_owner_q;
  assign rq1_readdatavalid = rd_pend_q &  rd_owner_q;
  assign rq0_readdata      = rq0_readdatavalid ? rd_word : rd0_hold_q;
  assign rq1_readdata      = rq1_readdatavalid ? rd_word : rd1_hold_q;

  always_comb begin
    state_d      = state_q;
    wipe_cnt_d   = wipe_cnt_q;
    zeroize_busy = 1'b1;
    zeroize_done = 1'b0;
    case (state_q)
      IDLE: begin
        zeroize_busy = 1'b0;
        if (zeroize_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        wipe_cnt_d = '0;
        state_d    = WIPE;
      end
      WIPE: begin
        if (wipe_cnt_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          wipe_cnt_d = wipe_cnt_q + ADDR_W'(1);
        end
      end
      DONE: begin
        zeroize_done = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wipe_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd0_hold_q <= '0;
      rd1_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      wipe_cnt_q <= wipe_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
      rd0_hold_q <= rq0_readdata;
      rd1_hold_q <= rq1_readdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crypto_wallet_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_crypto_wallet_ram_arbiter : scoreboard bench with RAM model       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_crypto_wallet_ram_arbiter;

  localparam int DEPTH  = 8000;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] rq0_address, rq1_address;
  logic [3:0]        rq0_byteenable, rq1_byteenable;
  logic              rq0_read, rq0_write, rq1_read, rq1_write;
  logic [31:0]       rq0_writedata, rq1_writedata;
  logic              rq0_waitrequest, rq1_waitrequest;
  logic [31:0]       rq0_readdata, rq1_readdata;
  logic              rq0_readdatavalid, rq1_readdatavalid;
  logic              zeroize_req, zeroize_busy, zeroize_done;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write;
  logic [31:0]       mem_writedata, mem_readdata;

  crypto_wallet_ram_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .rq0_address(rq0_address), .rq0_byteenable(rq0_byteenable), .rq0_read(rq0_read),
    .rq0_write(rq0_write), .rq0_writedata(rq0_writedata), .rq0_waitrequest(rq0_waitrequest),
    .rq0_readdata(rq0_readdata), .rq0_readdatavalid(rq0_readdatavalid),
    .rq1_address(rq1_address), .rq1_byteenable(rq1_byteenable), .rq1_read(rq1_read),
    .rq1_write(rq1_write), .rq1_writedata(rq1_writedata), .rq1_waitrequest(rq1_waitrequest),
    .rq1_readdata(rq1_readdata), .rq1_readdatavalid(rq1_readdatavalid),
    .zeroize_req(zeroize_req), .zeroize_busy(zeroize_busy), .zeroize_done(zeroize_done),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] b2w(input logic b);
    return {31'b0, b};
  endfunction

  // Single-port synchronous RAM, one-cycle read latency
  logic [31:0] ram [DEPTH];
  logic [31:0] ram_rd_q;
  logic        filled = 1'b0;
  assign mem_readdata = ram_rd_q;

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
      filled <= 1'b1;
    end else if (mem_chipselect && (int'(mem_address) < DEPTH)) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           ram_rd_q <= ram[mem_address];
    end
  end

  typedef struct packed { logic id; logic [31:0] data; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] exp_mem [DEPTH];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Read-response monitor: pops the scoreboard on every readdatavalid
  always @(negedge clk) begin
    if (rq0_readdatavalid || rq1_readdatavalid) begin
      if (sb_q.size() == 0) begin
        check("rdv_unexpected", {30'b0, rq1_readdatavalid, rq0_readdatavalid}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rdv_owner", {30'b0, rq1_readdatavalid, rq0_readdatavalid}, e.id ? 32'h2 : 32'h1);
        check("readdata", e.id ? rq1_readdata : rq0_readdata, e.data);
      end
    end
  end

  task automatic idle_inputs();
    rq0_read = 1'b0; rq0_write = 1'b0; rq0_address = '0; rq0_byteenable = 4'h0; rq0_writedata = '0;
    rq1_read = 1'b0; rq1_write = 1'b0; rq1_address = '0; rq1_byteenable = 4'h0; rq1_writedata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-requester access in IDLE; takes exactly one cycle
  task automatic acc(input logic id, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    logic inr;
    inr = int'(a) < DEPTH;
    if (!id) begin
      rq0_address = a; rq0_read = !wr; rq0_write = wr; rq0_byteenable = be; rq0_writedata = d;
    end else begin
      rq1_address = a; rq1_read = !wr; rq1_write = wr; rq1_byteenable = be; rq1_writedata = d;
    end
    @(negedge clk);
    check("wait_granted", b2w(id ? rq1_waitrequest : rq0_waitrequest), 32'h0);
    check("wait_other",   b2w(id ? rq0_waitrequest : rq1_waitrequest), 32'h1);
    check("mem_cs",       b2w(mem_chipselect), b2w(inr));
    check("mem_write",    b2w(mem_write), b2w(wr && inr));
    if (!wr) sb_q.push_back('{id: id, data: (inr ? exp_mem[a] : 32'h0)});
    else if (inr) exp_mem[a] = merge(exp_mem[a], d, be);
    step();
    idle_inputs();
  endtask

  int viol;
  int busy_viol;
  int done_at;

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat(i);
    idle_inputs();
    zeroize_req = 1'b0;

    // Reset state with live requests present
    repeat (3) @(posedge clk);
    #1;
    rq0_read = 1'b1; rq1_write = 1'b1; zeroize_req = 1'b1;
    #1;
    check("rst_wait0", b2w(rq0_waitrequest), 32'h1);
    check("rst_wait1", b2w(rq1_waitrequest), 32'h1);
    check("rst_rdv",   {30'b0, rq1_readdatavalid, rq0_readdatavalid}, 32'h0);
    check("rst_rd0",   rq0_readdata, 32'h0);
    check("rst_rd1",   rq1_readdata, 32'h0);
    check("rst_cs",    b2w(mem_chipselect), 32'h0);
    check("rst_mwr",   b2w(mem_write), 32'h0);
    check("rst_busy",  b2w(zeroize_busy), 32'h0);
    check("rst_done",  b2w(zeroize_done), 32'h0);
    idle_inputs();
    zeroize_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Contention: both read continuously, grants alternate from requester 0
    for (int i = 0; i < 6; i++) begin
      rq0_read = 1'b1; rq0_address = 13'h0020;
      rq1_read = 1'b1; rq1_address = 13'h0021;
      @(negedge clk);
      check("cont_wait0", b2w(rq0_waitrequest), b2w(i % 2 == 1));
      check("cont_wait1", b2w(rq1_waitrequest), b2w(i % 2 == 0));
      if (i % 2 == 0) sb_q.push_back('{id: 1'b0, data: exp_mem[32'h20]});
      else            sb_q.push_back('{id: 1'b1, data: exp_mem[32'h21]});
      step();
    end
    idle_inputs();
    step();

    // Solo read
    acc(1'b0, 1'b1, 13'h0010, 4'hF, 32'hCAFEF00D);
    acc(1'b0, 1'b0, 13'h0010, 4'hF, 32'h0);

    // Byte-lane write then readback
    acc(1'b1, 1'b1, 13'h1F3F, 4'hF,    32'h11111111);
    acc(1'b1, 1'b1, 13'h1F3F, 4'b0101, 32'hAABBCCDD);
    acc(1'b1, 1'b0, 13'h1F3F, 4'hF,    32'h0);

    // Out of range
    acc(1'b0, 1'b1, 13'd8000, 4'hF, 32'hFFFFFFFF);
    acc(1'b0, 1'b0, 13'd8000, 4'hF, 32'h0);
    acc(1'b0, 1'b0, 13'd7999, 4'hF, 32'h0);
    step();

    // Zeroize with a read in the same cycle the request rises
    zeroize_req = 1'b1;
    rq0_read = 1'b1; rq0_address = 13'd4000;
    @(negedge clk);
    check("zz_rd_wait", b2w(rq0_waitrequest), 32'h0);
    sb_q.push_back('{id: 1'b0, data: exp_mem[4000]});
    step();
    zeroize_req = 1'b0;
    rq0_read = 1'b1; rq0_address = 13'd5;
    rq1_read = 1'b1; rq1_address = 13'd6;
    viol = 0; busy_viol = 0; done_at = 0;
    for (int n = 1; n <= 9000; n++) begin
      @(negedge clk);
      if (rq0_waitrequest !== 1'b1 || rq1_waitrequest !== 1'b1) viol++;
      if (zeroize_busy !== 1'b1) busy_viol++;
      if (zeroize_done === 1'b1) begin
        done_at = n;
        break;
      end
    end
    check("zz_done_cycle", 32'(done_at), 32'd8002);
    check("zz_wait_viol", 32'(viol), 32'd0);
    check("zz_busy_viol", 32'(busy_viol), 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("zz_done_pulse", b2w(zeroize_done), 32'h0);
    check("zz_busy_fall",  b2w(zeroize_busy), 32'h0);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    step();
    acc(1'b0, 1'b0, 13'd0,    4'hF, 32'h0);
    acc(1'b1, 1'b0, 13'd4000, 4'hF, 32'h0);
    acc(1'b0, 1'b0, 13'd7999, 4'hF, 32'h0);

    // Reset in the middle of a wipe
    acc(1'b0, 1'b1, 13'd50,  4'hF, 32'h12345678);
    acc(1'b0, 1'b1, 13'd200, 4'hF, 32'h87654321);
    acc(1'b0, 1'b0, 13'd200, 4'hF, 32'h0);
    step();
    zeroize_req = 1'b1;
    @(negedge clk);
    step();
    zeroize_req = 1'b0;
    rq0_read = 1'b1; rq1_read = 1'b1;
    repeat (102) @(negedge clk);
    check("mid_busy", b2w(zeroize_busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_wait0", b2w(rq0_waitrequest), 32'h1);
    check("mid_wait1", b2w(rq1_waitrequest), 32'h1);
    check("mid_rdv",   {30'b0, rq1_readdatavalid, rq0_readdatavalid}, 32'h0);
    check("mid_rd0",   rq0_readdata, 32'h0);
    check("mid_cs",    b2w(mem_chipselect), 32'h0);
    check("mid_mwr",   b2w(mem_write), 32'h0);
    check("mid_busy0", b2w(zeroize_busy), 32'h0);
    idle_inputs();
    exp_mem[50] = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    acc(1'b0, 1'b0, 13'd50,  4'hF, 32'h0);
    acc(1'b1, 1'b0, 13'd200, 4'hF, 32'h0);
    step();
    step();
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crypto_wallet_ram_arbiter.md
# crypto_wallet_ram_arbiter

Shares the 8000×32 single-port on-chip RAM between two Avalon-MM requesters (requester 0: Nios II data master; requester 1: crypto engine key/hash buffer master) with round-robin arbitration. It also owns a hardware key-zeroization sequencer that drains in-flight reads and then overwrites every RAM word with zero. The block sits between the two masters and the RAM's s1 port, and is the only master of that port.

## Interface
Parameters:
- DEPTH, 8000: number of RAM words; valid addresses are 0..DEPTH-1.
- ADDR_W, 13: word address width.
- DATA_W, 32: data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- rqN_address  in  ADDR_W  word address, N ∈ {0,1}.
- rqN_byteenable  in  4  byte lanes for writes.
- rqN_read / rqN_write  in  1  access request; both high together is illegal and is treated as a write.
- rqN_writedata  in  32  write data.
- rqN_waitrequest  out  1  high = access not accepted this cycle.
- rqN_readdata  out  32  read data, qualified by rqN_readdatavalid.
- rqN_readdatavalid  out  1  one-cycle pulse.
- zeroize_req  in  1  level; sampled only in IDLE.
- zeroize_busy  out  1  high in DRAIN, WIPE and DONE.
- zeroize_done  out  1  one-cycle pulse in DONE.
- mem_address  out  ADDR_W, mem_byteenable out 4, mem_chipselect out 1, mem_write out 1, mem_writedata out 32: RAM port.
- mem_readdata  in  32  RAM output, valid one cycle after the read address is presented.

## Operation
- Outputs in reset: all waitrequest = 1, readdatavalid = 0, readdata = 0, mem_chipselect = 0, mem_write = 0, zeroize_busy = 0, zeroize_done = 0, FSM = IDLE, last_grant = 1, so requester 0 wins the first tie.
- FSM states are IDLE, DRAIN, WIPE and DONE.
- **IDLE, arbitration:**
  - A requester requests when read or write is high. At most one requester is granted per cycle.
  - A sole requester is granted.
  - If both request, the grant goes to the requester other than last_grant.
  - last_grant updates only when a grant is issued.
- **Granted access:**
  - The access drives the mem_* outputs combinationally in the same cycle, and that requester's waitrequest = 0.
  - Every requester not granted has waitrequest = 1, including requesters that are not requesting.
- **Reads:**
  - A registered owner tag records the granted reader.
  - Next cycle, that requester gets readdatavalid = 1 with readdata = mem_readdata.
  - readdata holds its last value otherwise.
- **Writes:** mem_write = 1 and byteenable are passed through. Writes produce no response.
- **Out-of-range address (≥ DEPTH):**
  - The access is accepted (waitrequest = 0) with mem_chipselect = 0.
  - A write is dropped.
  - A read returns readdata = 0 with readdatavalid the next cycle.
- **IDLE → DRAIN** when zeroize_req = 1. A request in that same IDLE cycle is still arbitrated and granted normally.
- **DRAIN (1 cycle):** all waitrequest = 1. Any read issued in the previous cycle completes normally.
- **WIPE:**
  - wipe_cnt runs 0..DEPTH-1, one word per cycle.
  - Each cycle: mem_chipselect = 1, mem_write = 1, byteenable = 4'hF, writedata = 0.
  - All waitrequest = 1.
  - After wipe_cnt = DEPTH-1 the FSM moves to DONE.
- **DONE (1 cycle):** zeroize_done = 1, then IDLE.
- **zeroize_req handling:** ignored while busy. A request still high on return to IDLE starts a new wipe.
- **reset_n low mid-wipe:** everything returns to reset values immediately and the wipe is abandoned. The RAM is partially cleared; software re-issues zeroize_req.
- wipe_cnt width is ADDR_W; its final value DEPTH-1 = 7999 must not wrap.

## Timing
- Grant and waitrequest are combinational from the request inputs and registered state. There are no combinational paths from mem_readdata to waitrequest.
- Read latency is fixed at 1 cycle (address accepted at edge k, data valid before edge k+1). Back-to-back reads by either requester sustain 1 access per cycle.
- Zeroize with zeroize_req sampled high at edge k:
  - DRAIN in cycle k+1.
  - WIPE in cycles k+2..k+DEPTH+1.
  - DONE in cycle k+DEPTH+2 (k+8002).
  - zeroize_busy falls in the following cycle.

## Structure
- Package crypto_wallet_ram_arb_pkg holds:
  - the state enum (IDLE, DRAIN, WIPE, DONE);
  - DEPTH_DEF = 8000 and ADDR_W_DEF = 13;
  - the ZERO_WORD constant.
- One sub-module, crypto_wallet_rr_arb2: 2-way round-robin grant logic holding last_grant, with inputs req[1:0] and enable, and output gnt[1:0].
- The top level holds the FSM, the wipe counter, the owner tag, the range check and the muxing.

## Test plan
- **Solo read:** rq0 reads addr 0x0010 holding 0xCAFEF00D → waitrequest 0 the same cycle; rq0_readdatavalid with 0xCAFEF00D one cycle later; rq1 sees no readdatavalid.
- **Contention:** both hold reads continuously for 6 cycles from reset → grants alternate 0,1,0,1,0,1; each readdatavalid lands on the correct requester.
- **Byte write:** rq1 writes 0xAABBCCDD with byteenable 4'b0101 over 0x11111111 at 0x1F3F, then reads it back → 0x11BB11DD.
- **Out of range:** rq0 writes 0xFFFFFFFF at address 8000, then reads 8000 → mem_chipselect stays 0; the read returns 0 with readdatavalid.
- **Zeroize:**
  - Fill the RAM with nonzero data; rq0 issues a read in the same cycle zeroize_req rises.
  - Required: the read completes; both waitrequests stay 1 for 8001 cycles; zeroize_done pulses at k+8002; reads of addresses 0, 4000 and 7999 return 0.
- **Reset mid-wipe:** assert reset_n low at wipe_cnt = 100 → all outputs return to reset values asynchronously; word 50 reads 0 and word 200 keeps its old data after release.
